// File: rtl/edsac_sram_store.sv
// EDSAC 1024 x 18-bit main store served from a 16-bit async SRAM, two halfwords per word.
// Fixed-length access: req accepted in IDLE, ack after 2*WAIT_CYCLES+5 cycles; req ignored while busy.
module edsac_sram_store #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [17:0] wdata,
  output logic [17:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [18:0] sram_adr,
  output logic [15:0] sram_dat_out,
  output logic        sram_dat_oe,
  input  logic [15:0] sram_dat_in,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LO   = 3'd1;
  localparam logic [2:0] GAP1 = 3'd2;
  localparam logic [2:0] HI   = 3'd3;
  localparam logic [2:0] GAP2 = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [9:0]    addr_q, addr_d;
  logic [17:0]   wdata_q, wdata_d;
  logic [17:0]   rdata_q, rdata_d;
  logic [18:0]   adr_q, adr_d;
  logic [15:0]   dout_q, dout_d;
  logic          doe_q, doe_d;
  logic          cs_n_q, cs_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          phase_d, half_d, strobe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LO;
        cnt_d   = CNT_LOAD;
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
      end
      LO: if (cnt_q == '0) begin
        state_d = GAP1;
        if (!we_q) rdata_d[15:0] = sram_dat_in;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      GAP1: begin
        state_d = HI;
        cnt_d   = CNT_LOAD;
      end
      // Only the sandwich digit and top data bit live in the high halfword.
      HI: if (cnt_q == '0) begin
        state_d = GAP2;
        if (!we_q) rdata_d[17:16] = sram_dat_in[1:0];
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      GAP2:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every SRAM pin comes straight off a flop.
  always_comb begin
    phase_d  = (state_d == LO) || (state_d == GAP1) || (state_d == HI) || (state_d == GAP2);
    half_d   = (state_d == HI) || (state_d == GAP2);
    strobe_d = (state_d == LO) || (state_d == HI);
    adr_d    = phase_d ? {8'b0, addr_d, half_d} : adr_q;
    cs_n_d   = !strobe_d;
    oe_n_d   = !(strobe_d && !we_d);
    we_n_d   = !(strobe_d && we_d);
    doe_d    = phase_d && we_d;
    dout_d   = dout_q;
    if (doe_d) dout_d = half_d ? {14'b0, wdata_d[17:16]} : wdata_d[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      adr_q   <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign rdata        = rdata_q;
  assign ack          = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign sram_adr     = adr_q;
  assign sram_dat_out = dout_q;
  assign sram_dat_oe  = doe_q;
  assign sram_cs_n    = cs_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_edsac_sram_store.sv
// Directed bench for edsac_sram_store: W=1 instance for data paths, W=2 instance for handshake timing.
`timescale 1ns/1ps
module tb_edsac_sram_store;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, we0 = 0, ack0, busy0, doe0, cs0, oe0, wen0;
  logic [9:0]  addr0 = '0;
  logic [17:0] wdata0 = '0, rdata0;
  logic [18:0] adr0;
  logic [15:0] dout0, din0;
  logic        req1 = 0, we1 = 0, ack1, busy1, doe1, cs1, oe1, wen1;
  logic [9:0]  addr1 = '0;
  logic [17:0] wdata1 = '0, rdata1;
  logic [18:0] adr1;
  logic [15:0] dout1, din1;

  logic [15:0] mem0 [0:2047];
  logic [15:0] mem1 [0:2047];
  logic        bd_we = 0;
  logic [10:0] bd_a = '0;
  logic [15:0] bd_d = '0;
  logic        rst_e = 1'b1;

  int checks = 0;
  int failures = 0;

  edsac_sram_store #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .sram_adr(adr0), .sram_dat_out(dout0),
    .sram_dat_oe(doe0), .sram_dat_in(din0), .sram_cs_n(cs0), .sram_oe_n(oe0), .sram_we_n(wen0)
  );

  edsac_sram_store #(.WAIT_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ack(ack1), .busy(busy1), .sram_adr(adr1), .sram_dat_out(dout1),
    .sram_dat_oe(doe1), .sram_dat_in(din1), .sram_cs_n(cs1), .sram_oe_n(oe1), .sram_we_n(wen1)
  );

  // Async SRAM models: reads are combinational while CS and OE are low.
  always @(posedge clk) begin
    rst_e <= rst;
    if (bd_we) mem0[bd_a] <= bd_d;
    else if (!cs0 && !wen0 && doe0) mem0[adr0[10:0]] <= dout0;
    if (!cs1 && !wen1 && doe1) mem1[adr1[10:0]] <= dout1;
  end
  assign din0 = (!cs0 && !oe0) ? mem0[adr0[10:0]] : 16'h5A5A;
  assign din1 = (!cs1 && !oe1) ? mem1[adr1[10:0]] : 16'h5A5A;

  task automatic backdoor(input logic [10:0] a, input logic [15:0] d);
    bd_a = a; bd_d = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // One access on the W=1 instance; lat is the cycle of ack counted from the req edge, -1 on timeout.
  task automatic acc0(input logic w, input logic [9:0] a, input logic [17:0] d,
                      output int lat, output logic [18:0] af, output logic [18:0] al);
    lat = -1; af = '1; al = '1;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    @(posedge clk); #1;
    req0 = 1'b0; we0 = ~w; addr0 = ~a; wdata0 = ~d;
    for (int n = 1; n <= 40; n++) begin
      if (!cs0) begin
        if (af === 19'h7FFFF) af = adr0;
        al = adr0;
      end
      if (ack0) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int lat, wlow;
    logic [18:0] af, al;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cs0, oe0, wen0, doe0} !== 4'b1110) begin failures++; $display("FAIL reset_strobes got=%b want=1110", {cs0, oe0, wen0, doe0}); end
    checks++; if ({busy0, ack0} !== 2'b00) begin failures++; $display("FAIL reset_busy_ack got=%b want=00", {busy0, ack0}); end
    checks++; if (rdata0 !== 18'h0 || adr0 !== 19'h0) begin failures++; $display("FAIL reset_rdata_adr got=%h/%h want=0/0", rdata0, adr0); end
    rst = 1'b0;
    backdoor(11'd40, 16'h1234);
    backdoor(11'd41, 16'hFFF3);
    acc0(1'b0, 10'd20, 18'h0, lat, af, al);
    checks++; if (rdata0 !== 18'h3_1234) begin failures++; $display("FAIL pre_reset_read got=%h want=31234", rdata0); end
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 10'd30; wdata0 = 18'h1_5555;
    @(posedge clk); #1;
    req0 = 1'b0;
    checks++; if (wen0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL midlo_write got we_n=%b busy=%b want 0/1", wen0, busy0); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({cs0, oe0, wen0, doe0, busy0, ack0} !== 6'b111000) begin failures++; $display("FAIL midlo_reset_ctl got=%b want=111000", {cs0, oe0, wen0, doe0, busy0, ack0}); end
    checks++; if (rdata0 !== 18'h0 || adr0 !== 19'h0 || dout0 !== 16'h0) begin failures++; $display("FAIL midlo_reset_data got=%h/%h/%h want=0/0/0", rdata0, adr0, dout0); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    wlow = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (!wen0 || ack0 || busy0) wlow++;
    end
    checks++; if (wlow !== 0) begin failures++; $display("FAIL post_reset_quiet got=%0d active cycles want=0", wlow); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [18:0] af, al;
    acc0(1'b1, 10'd5, 18'h2_ABCD, lat, af, al);
    checks++; if (lat !== 7) begin failures++; $display("FAIL write_latency got=%0d want=7", lat); end
    checks++; if (af !== 19'd10 || al !== 19'd11) begin failures++; $display("FAIL write_adr got=%0d..%0d want=10..11", af, al); end
    checks++; if (mem0[10] !== 16'hABCD || mem0[11] !== 16'h0002) begin failures++; $display("FAIL write_halves got=%h/%h want=abcd/0002", mem0[10], mem0[11]); end
    checks++; if (rdata0 !== 18'h0) begin failures++; $display("FAIL write_keeps_rdata got=%h want=0", rdata0); end
    acc0(1'b0, 10'd5, 18'h0, lat, af, al);
    checks++; if (lat !== 7) begin failures++; $display("FAIL read_latency got=%0d want=7", lat); end
    checks++; if (rdata0 !== 18'h2_ABCD) begin failures++; $display("FAIL read_word got=%h want=2abcd", rdata0); end
  endtask

  task automatic test_boundary();
    int lat;
    logic [18:0] af, al;
    acc0(1'b1, 10'd0, 18'h1_2345, lat, af, al);
    checks++; if (af !== 19'd0 || al !== 19'd1) begin failures++; $display("FAIL adr_low got=%0d..%0d want=0..1", af, al); end
    acc0(1'b1, 10'd1023, 18'h3_0F0F, lat, af, al);
    checks++; if (af !== 19'd2046 || al !== 19'd2047) begin failures++; $display("FAIL adr_high got=%0d..%0d want=2046..2047", af, al); end
    checks++; if (mem0[0] !== 16'h2345 || mem0[1] !== 16'h0001) begin failures++; $display("FAIL mem_low got=%h/%h want=2345/0001", mem0[0], mem0[1]); end
    checks++; if (mem0[2046] !== 16'h0F0F || mem0[2047] !== 16'h0003) begin failures++; $display("FAIL mem_high got=%h/%h want=0f0f/0003", mem0[2046], mem0[2047]); end
    acc0(1'b0, 10'd0, 18'h0, lat, af, al);
    checks++; if (rdata0 !== 18'h1_2345) begin failures++; $display("FAIL read_low got=%h want=12345", rdata0); end
    acc0(1'b0, 10'd1023, 18'h0, lat, af, al);
    checks++; if (rdata0 !== 18'h3_0F0F) begin failures++; $display("FAIL read_high got=%h want=30f0f", rdata0); end
  endtask

  task automatic test_high_mask();
    int lat;
    logic [18:0] af, al;
    backdoor(11'd2000, 16'hFFFF);
    backdoor(11'd2001, 16'hFFFF);
    acc0(1'b0, 10'd1000, 18'h0, lat, af, al);
    checks++; if (rdata0 !== 18'h3_FFFF) begin failures++; $display("FAIL mask_all_ones got=%h want=3ffff", rdata0); end
    backdoor(11'd1900, 16'h0000);
    backdoor(11'd1901, 16'hFFFD);
    acc0(1'b0, 10'd950, 18'h0, lat, af, al);
    checks++; if (rdata0 !== 18'h1_0000) begin failures++; $display("FAIL mask_high_bits got=%h want=10000", rdata0); end
  endtask

  task automatic test_back_to_back();
    int rise [$];
    int acks, wide, low;
    logic pb, pa;
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd3;
    pb = busy1; pa = 1'b0; acks = 0; wide = 0; low = 0;
    for (int i = 1; i <= 26; i++) begin
      @(posedge clk); #1;
      if (i == 20) req1 = 1'b0;
      if (busy1 && !pb) rise.push_back(i);
      if (ack1) begin
        acks++;
        if (pa) wide++;
      end
      if (!busy1 && i > 1 && i < 19) low++;
      pb = busy1; pa = ack1;
    end
    checks++; if (rise.size() !== 2) begin failures++; $display("FAIL held_accept_count got=%0d want=2", rise.size()); end
    else begin
      checks++; if (rise[0] !== 1 || rise[1] !== 11) begin failures++; $display("FAIL held_accept_cycles got=%0d,%0d want=1,11", rise[0], rise[1]); end
    end
    checks++; if (acks !== 2 || wide !== 0) begin failures++; $display("FAIL held_ack got=%0d pulses %0d wide want=2/0", acks, wide); end
    checks++; if (low !== 1) begin failures++; $display("FAIL held_busy_gap got=%0d want=1", low); end
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'd7; wdata1 = 18'h1_0F0F;
    @(posedge clk); #1;
    req1 = 1'b0; we1 = 1'b0; addr1 = 10'd9;
    acks = 0; low = 0; pb = busy1;
    for (int j = 2; j <= 15; j++) begin
      req1 = (j == 3 || j == 7);
      @(posedge clk); #1;
      if (busy1 && !pb) low++;
      if (ack1) acks = acks + j * 100;
      pb = busy1;
    end
    req1 = 1'b0;
    checks++; if (low !== 0 || acks !== 900) begin failures++; $display("FAIL midaccess_req got=%0d extra accepts ack_code=%0d want=0/900", low, acks); end
    checks++; if (mem1[14] !== 16'h0F0F || mem1[15] !== 16'h0001) begin failures++; $display("FAIL w2_write got=%h/%h want=0f0f/0001", mem1[14], mem1[15]); end
  endtask

  initial begin
    fork
      begin : protocol
        logic p_wen0, p_wen1;
        logic [18:0] p_adr0, p_adr1;
        p_wen0 = 1'b1; p_wen1 = 1'b1; p_adr0 = '0; p_adr1 = '0;
        forever begin
          @(negedge clk);
          if (!rst_e) begin
            checks++; if (!wen0 && !oe0) begin failures++; $display("FAIL proto0_we_oe both low at %0t", $time); end
            checks++; if (doe0 && !(oe0 && busy0 && !ack0)) begin failures++; $display("FAIL proto0_dat_oe got oe=1 outside write at %0t", $time); end
            checks++; if (cs0 && !(oe0 && wen0)) begin failures++; $display("FAIL proto0_gap got oe_n=%b we_n=%b want 1/1", oe0, wen0); end
            checks++; if (!p_wen0 && adr0 !== p_adr0) begin failures++; $display("FAIL proto0_adr_stable got=%h want=%h", adr0, p_adr0); end
            checks++; if (!wen1 && !oe1) begin failures++; $display("FAIL proto1_we_oe both low at %0t", $time); end
            checks++; if (doe1 && !(oe1 && busy1 && !ack1)) begin failures++; $display("FAIL proto1_dat_oe got oe=1 outside write at %0t", $time); end
            checks++; if (cs1 && !(oe1 && wen1)) begin failures++; $display("FAIL proto1_gap got oe_n=%b we_n=%b want 1/1", oe1, wen1); end
            checks++; if (!p_wen1 && adr1 !== p_adr1) begin failures++; $display("FAIL proto1_adr_stable got=%h want=%h", adr1, p_adr1); end
          end
          p_wen0 = wen0; p_adr0 = adr0; p_wen1 = wen1; p_adr1 = adr1;
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
      end
    join_none
    test_reset();
    test_write_read();
    test_boundary();
    test_high_mask();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edsac_sram_store.md
# edsac_sram_store

Synchronous controller that serves the EDSAC main store (1024 × 18-bit short words: 17 data bits plus sandwich digit) from the board's external 16-bit asynchronous SRAM. It is the SRAM-side counterpart of the chip top, which currently ties the SRAM lines idle. The chip top wires this block's strobes to RAMCS/RAMOE/RAMWE, ADR and a tristated DAT bus. Each store word occupies two consecutive SRAM halfwords, and every access is a fixed-length two-phase sequence behind a req/ack handshake.

## Interface
- WAIT_CYCLES, default 1: active strobe cycles per halfword minus one (legal ≥ 1).
- clk  in  1  100 MHz board clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  10  store word address 0..1023; sampled with req.
- wdata  in  18  write word; sampled with req.
- rdata  out  18  read word; valid from the ack cycle until the next read completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance through the ack cycle.
- sram_adr  out  19  SRAM address.
- sram_dat_out  out  16  SRAM write data.
- sram_dat_oe  out  1  1 = chip top drives DAT.
- sram_dat_in  in  16  SRAM read data.
- sram_cs_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.

## Operation
- States: IDLE, LO, GAP1, HI, GAP2, DONE.
- IDLE: all strobes 1, sram_dat_oe 0, busy 0. On req=1, latch we, addr and wdata, then go to LO. req is ignored in every other state.
- sram_adr = {8'b0, addr_l, half}, with half=0 in LO/GAP1 and half=1 in HI/GAP2. sram_adr holds its last value in IDLE.
- LO and HI each last WAIT_CYCLES+1 cycles, timed by a down-counter. sram_cs_n=0 throughout.
- Read: sram_oe_n=0 and sram_we_n=1. On the last LO cycle, capture sram_dat_in[15:0] into rdata[15:0]. On the last HI cycle, capture sram_dat_in[1:0] into rdata[17:16].
- Write: sram_oe_n=1, sram_we_n=0, sram_dat_oe=1. sram_dat_out = wdata_l[15:0] in LO/GAP1 and {14'b0, wdata_l[17:16]} in HI/GAP2.
- GAP1/GAP2: one cycle each with cs_n, oe_n and we_n all 1. Address and (for writes) data plus dat_oe stay held, which gives address and data hold after the WE rising edge.
- DONE: one cycle with ack=1, strobes 1, dat_oe 0, then IDLE.
- A write never modifies rdata. On read, SRAM bits [15:2] of the high halfword are discarded.
- Reset, including mid-access: at the next edge state=IDLE, all strobes 1, sram_dat_oe 0, ack 0, busy 0, rdata 0, sram_adr 0, sram_dat_out 0. Any access in flight is abandoned with no ack.

## Timing
- Let W = WAIT_CYCLES and let req be sampled in IDLE at edge k.
- LO occupies cycles k+1..k+W+1.
- GAP1 at k+W+2.
- HI occupies k+W+3..k+2W+3.
- GAP2 at k+2W+4.
- DONE (ack=1) at k+2W+5; IDLE again at k+2W+6.
- Latency from the req edge to ack is 2W+5 cycles; this is 7 cycles for W=1.
- A req held high continuously is re-accepted in the first IDLE cycle after DONE. There is no back-to-back acceptance in the DONE cycle.
- Strobe outputs and sram_adr are registered, so there is no combinational path from req to any SRAM pin.
- The write strobe is never low in a cycle where sram_adr changes.

## Test plan
- Reset: hold rst 3 cycles, with one assertion mid-LO of a write. Required: next cycle all strobes 1, sram_dat_oe=0, busy=0, ack=0, rdata=0, and no further we_n pulse.
- Write then read, W=1: write addr=10'd5, wdata=18'h2_ABCD. Required: halfword 10 written with 16'hABCD and halfword 11 with 16'h0002. ack 7 cycles after req. A model SRAM read of addr 5 returns rdata=18'h2_ABCD.
- Boundary addresses: write/read addr=0 and addr=1023. Required: sram_adr hits 19'd0/1 and 19'd2046/2047, and both words round-trip intact.
- High-half masking: model SRAM returns 16'hFFFF for both halves. Required: rdata=18'h3_FFFF, with no bits beyond [1:0] taken from the high halfword.
- Held req and mid-access req: req held high for 20 cycles, W=2. Required: accesses accepted at k and k+2W+6 only, ack pulses exactly one cycle each, and busy is never low between accesses except in IDLE. Pulses on req during LO/HI are ignored.
- Strobe protocol checker throughout: we_n and oe_n are never both 0. sram_dat_oe=1 only during write phases. we_n=0 never coincides with a sram_adr change. Each GAP cycle has cs_n=1.
